uart_tx_arbiter: RTL and testbench

// - Shares the single UART sender (TX_EN/TX_DATA/TX_STATUS interface) among NUM_REQ byte producers
//   (CPU MMIO path, debug monitor, ...) using round-robin arbitration.
// - Sequences one frame at a time: grant -> TX_EN pulse -> wait frame start -> wait frame done.
// - Sits between the requesters and the UART sender; the sender itself is unchanged.

---
 rtl/uart_arb_pkg.sv | 15 +
 rtl/rr_pick.sv | 31 +++
 rtl/uart_tx_arbiter.sv | 150 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_arb_pkg;

    localparam int UART_BYTE_W       = 8;
    localparam int MAX_REQ           = 8;
    localparam int DEF_START_TIMEOUT = 8;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        LAUNCH     = 2'd1,
        WAIT_START = 2'd2,
        WAIT_DONE  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after (rr_ptr + 1) mod NUM_REQ.
module rr_pick #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic               valid,
    output logic [IDX_W-1:0]   index
);

    // cand[k] is the requester at priority rank k (rank 0 = just after the last winner).
    logic [IDX_W-1:0] cand [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
        assign cand[gi] = IDX_W'((int'(rr_ptr) + gi + 1) % NUM_REQ);
    end

    // Scan from lowest priority up so the highest-priority match is written last.
    always_comb begin
        valid = 1'b0;
        index = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[cand[k]]) begin
                valid = 1'b1;
                index = cand[k];
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART sender among NUM_REQ byte producers.
// Defining UART_TX_ARB_LOCK_EN adds req_last and keeps a requester granted until its packet ends.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter  int NUM_REQ       = 4,
    parameter  int START_TIMEOUT = DEF_START_TIMEOUT,
    localparam int IDX_W         = $clog2(NUM_REQ),
    localparam int CNT_W         = $clog2(START_TIMEOUT + 1)
) (
    input  logic                           CLK,
    input  logic                           Reset,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [UART_BYTE_W*NUM_REQ-1:0] req_data,
`ifdef UART_TX_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]             req_last,
`endif
    output logic [NUM_REQ-1:0]             ack,
    output logic                           tx_en,
    output logic [UART_BYTE_W-1:0]         tx_data,
    input  logic                           tx_status,
    output logic [IDX_W-1:0]               grant_id,
    output logic                           busy,
    output logic                           err_timeout
);

    arb_state_t             state_reg;
    logic [IDX_W-1:0]       rr_ptr_reg;
    logic [IDX_W-1:0]       grant_id_reg;
    logic [UART_BYTE_W-1:0] tx_data_reg;
    logic [NUM_REQ-1:0]     ack_reg;
    logic                   tx_en_reg;
    logic                   err_reg;
    logic [CNT_W-1:0]       cnt_reg;
    logic [CNT_W-1:0]       cnt_next;

    logic [UART_BYTE_W-1:0] req_byte [NUM_REQ];
    logic [NUM_REQ-1:0]     cand_req;
    logic                   pick_valid;
    logic [IDX_W-1:0]       pick_idx;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign req_byte[gi] = req_data[UART_BYTE_W*gi +: UART_BYTE_W];
    end

`ifdef UART_TX_ARB_LOCK_EN
    logic               lock_reg;
    logic [NUM_REQ-1:0] lock_mask;

    // While locked and the owner still requests, hide everyone else from the picker.
    // rr_ptr equals the owner, so the picker wraps straight back to it.
    assign lock_mask = NUM_REQ'(1) << grant_id_reg;
    assign cand_req  = (lock_reg && req[grant_id_reg]) ? (req & lock_mask) : req;
`else
    assign cand_req  = req;
`endif

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .req    (cand_req),
        .rr_ptr (rr_ptr_reg),
        .valid  (pick_valid),
        .index  (pick_idx)
    );

    assign cnt_next = cnt_reg + CNT_W'(1);

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_reg    <= IDLE;
            rr_ptr_reg   <= IDX_W'(NUM_REQ - 1);
            grant_id_reg <= '0;
            tx_data_reg  <= '0;
            ack_reg      <= '0;
            tx_en_reg    <= 1'b0;
            err_reg      <= 1'b0;
            cnt_reg      <= '0;
`ifdef UART_TX_ARB_LOCK_EN
            lock_reg     <= 1'b0;
`endif
        end else begin
            ack_reg   <= '0;
            tx_en_reg <= 1'b0;
            err_reg   <= 1'b0;

            case (state_reg)
                IDLE: begin
`ifdef UART_TX_ARB_LOCK_EN
                    if (lock_reg && !req[grant_id_reg]) begin
                        lock_reg <= 1'b0;
                    end
`endif
                    // A sender still busy (e.g. frame begun before reset) blocks any grant.
                    if (tx_status && pick_valid) begin
                        tx_data_reg  <= req_byte[pick_idx];
                        grant_id_reg <= pick_idx;
                        rr_ptr_reg   <= pick_idx;
                        ack_reg      <= NUM_REQ'(1) << pick_idx;
                        tx_en_reg    <= 1'b1;
                        state_reg    <= LAUNCH;
`ifdef UART_TX_ARB_LOCK_EN
                        lock_reg     <= !req_last[pick_idx];
`endif
                    end
                end

                LAUNCH: begin
                    cnt_reg   <= '0;
                    state_reg <= WAIT_START;
                end

                WAIT_START: begin
                    if (!tx_status) begin
                        state_reg <= WAIT_DONE;
                    end else begin
                        cnt_reg <= cnt_next;
                        // Abort is registered as the counter reaches START_TIMEOUT-1, so
                        // err_timeout lands START_TIMEOUT cycles after the tx_en pulse.
                        if (cnt_next == CNT_W'(START_TIMEOUT - 1)) begin
                            err_reg   <= 1'b1;
                            state_reg <= IDLE;
`ifdef UART_TX_ARB_LOCK_EN
                            lock_reg  <= 1'b0;
`endif
                        end
                    end
                end

                WAIT_DONE: begin
                    if (tx_status) begin
                        state_reg <= IDLE;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign ack         = ack_reg;
    assign tx_en       = tx_en_reg;
    assign tx_data     = tx_data_reg;
    assign grant_id    = grant_id_reg;
    assign busy        = (state_reg != IDLE);
    assign err_timeout = err_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a simple UART sender model.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ = 4;
    localparam int FRAME   = 160;

    logic                 CLK       = 1'b0;
    logic                 Reset     = 1'b1;
    logic [NUM_REQ-1:0]   req       = '0;
    logic [8*NUM_REQ-1:0] req_data  = '0;
`ifdef UART_TX_ARB_LOCK_EN
    logic [NUM_REQ-1:0]   req_last  = '0;
`endif
    logic                 tx_status = 1'b1;
    logic [NUM_REQ-1:0]   ack;
    logic                 tx_en;
    logic [7:0]           tx_data;
    logic [1:0]           grant_id;
    logic                 busy;
    logic                 err_timeout;

    // Sender model controls: model_en=0 means it never starts a frame, hold_low pins status low.
    logic model_en  = 1'b1;
    logic hold_low  = 1'b0;
    int   frame_cnt = 0;

    int checks = 0;
    int errors = 0;

    uart_tx_arbiter #(
        .NUM_REQ       (NUM_REQ),
        .START_TIMEOUT (8)
    ) dut (
        .CLK         (CLK),
        .Reset       (Reset),
        .req         (req),
        .req_data    (req_data),
`ifdef UART_TX_ARB_LOCK_EN
        .req_last    (req_last),
`endif
        .ack         (ack),
        .tx_en       (tx_en),
        .tx_data     (tx_data),
        .tx_status   (tx_status),
        .grant_id    (grant_id),
        .busy        (busy),
        .err_timeout (err_timeout)
    );

    always #5 CLK = ~CLK;

    // Status falls in the tx_en cycle's second half and rises FRAME cycles later.
    always @(negedge CLK) begin
        if (hold_low) begin
            tx_status = 1'b0;
            frame_cnt = 0;
        end else if (!model_en) begin
            tx_status = 1'b1;
            frame_cnt = 0;
        end else if (frame_cnt > 0) begin
            frame_cnt = frame_cnt - 1;
            if (frame_cnt == 0) tx_status = 1'b1;
        end else if (tx_en) begin
            tx_status = 1'b0;
            frame_cnt = FRAME;
        end else begin
            tx_status = 1'b1;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_txen(input int budget, output int cycles);
        cycles = 0;
        do begin
            tick();
            cycles++;
        end while (tx_en !== 1'b1 && cycles < budget);
    endtask

    task automatic wait_idle(input int budget, input logic [7:0] hold_data,
                             output int cycles, output int ntx, output bit stable);
        cycles = 0;
        ntx    = 0;
        stable = 1'b1;
        do begin
            tick();
            cycles++;
            if (tx_en === 1'b1) ntx++;
            if (busy === 1'b1 && tx_data !== hold_data) stable = 1'b0;
        end while (busy !== 1'b0 && cycles < budget);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ack"},   32'(ack),         32'h0);
        check({tag, "_txen"},  32'(tx_en),       32'h0);
        check({tag, "_data"},  32'(tx_data),     32'h0);
        check({tag, "_gid"},   32'(grant_id),    32'h0);
        check({tag, "_busy"},  32'(busy),        32'h0);
        check({tag, "_err"},   32'(err_timeout), 32'h0);
    endtask

    initial begin
        int cyc;
        int ntx;
        bit stable;
        int exp_gid [5] = '{0, 1, 2, 3, 0};
        int exp_gap [5] = '{1, 162, 162, 162, 162};
        logic [7:0] exp_byte [5] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};

        // Reset values
        tick();
        tick();
        check_reset_values("rst");
        Reset = 1'b0;

        // Single request from 0: tx_en/ack one cycle later, data held for the frame
        req      = 4'b0001;
        req_data = 32'h000000A5;
        wait_txen(10, cyc);
        check("A_lat",  32'(cyc),      32'd1);
        check("A_txen", 32'(tx_en),    32'h1);
        check("A_ack",  32'(ack),      32'h1);
        check("A_data", 32'(tx_data),  32'hA5);
        check("A_busy", 32'(busy),     32'h1);
        req = 4'b0000;
        wait_idle(400, 8'hA5, cyc, ntx, stable);
        check("A_frame_len", 32'(cyc),    32'd161);
        check("A_extra_txen", 32'(ntx),   32'd0);
        check("A_data_hold", 32'(stable), 32'd1);

        // All four requesting: rotation 0,1,2,3,0, one tx_en per frame
        Reset = 1'b1;
        tick();
        Reset    = 1'b0;
        req      = 4'b1111;
        req_data = 32'h13121110;
        for (int k = 0; k < 5; k++) begin
            wait_txen(400, cyc);
            check($sformatf("B_gap%0d", k),  32'(cyc),      32'(exp_gap[k]));
            check($sformatf("B_gid%0d", k),  32'(grant_id), 32'(exp_gid[k]));
            check($sformatf("B_ack%0d", k),  32'(ack),      32'(1) << exp_gid[k]);
            check($sformatf("B_data%0d", k), 32'(tx_data),  32'(exp_byte[k]));
            if (k == 4) req = 4'b0000;
        end
        wait_idle(400, 8'h10, cyc, ntx, stable);
        check("B_idle", 32'(busy), 32'h0);
        check("B_no_more_txen", 32'(ntx), 32'd0);

        // Sender never starts: err_timeout exactly 8 cycles after the tx_en cycle
        model_en = 1'b0;
        req      = 4'b0100;
        req_data = 32'h005A00C3;
        wait_txen(10, cyc);
        check("T_lat", 32'(cyc),      32'd1);
        check("T_gid", 32'(grant_id), 32'd2);
        req = 4'b0000;
        for (int k = 0; k < 7; k++) tick();
        check("T_err_early", 32'(err_timeout), 32'h0);
        check("T_busy_early", 32'(busy),       32'h1);
        tick();
        check("T_err_pulse", 32'(err_timeout), 32'h1);
        check("T_busy_after", 32'(busy),       32'h0);
        tick();
        check("T_err_clear", 32'(err_timeout), 32'h0);
        check("T_no_txen",   32'(tx_en),       32'h0);

        // Status held low across reset: no grant until it rises, then requester 2
        model_en = 1'b1;
        hold_low = 1'b1;
        Reset    = 1'b1;
        tick();
        Reset = 1'b0;
        req   = 4'b0100;
        ntx   = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (tx_en === 1'b1) ntx++;
        end
        check("H_blocked_txen", 32'(ntx),  32'd0);
        check("H_blocked_busy", 32'(busy), 32'h0);
        hold_low = 1'b0;
        wait_txen(10, cyc);
        check("H_lat",  32'(cyc),      32'd1);
        check("H_gid",  32'(grant_id), 32'd2);
        check("H_ack",  32'(ack),      32'h4);
        check("H_data", 32'(tx_data),  32'h5A);
        req = 4'b0000;

        // Reset while in WAIT_DONE, then the running frame gates the next grant
        for (int k = 0; k < 10; k++) tick();
        check("R_busy_before", 32'(busy), 32'h1);
        Reset = 1'b1;
        tick();
        check_reset_values("R");
        Reset = 1'b0;
        req   = 4'b0001;
        wait_txen(400, cyc);
        check("R_wait", 32'(cyc),      32'd150);
        check("R_gid",  32'(grant_id), 32'd0);
        check("R_data", 32'(tx_data),  32'hC3);
        req = 4'b0000;
        wait_idle(400, 8'hC3, cyc, ntx, stable);
        check("R_idle", 32'(busy), 32'h0);

`ifdef UART_TX_ARB_LOCK_EN
        // Packet lock: three bytes from 0 (last flag on the third), then requester 1
        Reset = 1'b1;
        tick();
        Reset    = 1'b0;
        req_last = 4'b0000;
        req_data = 32'h0000B2A1;
        req      = 4'b0011;
        for (int k = 0; k < 4; k++) begin
            wait_txen(400, cyc);
            check($sformatf("L_gid%0d", k), 32'(grant_id), (k < 3) ? 32'd0 : 32'd1);
            if (k == 1) req_last = 4'b0001;
            if (k == 2) req = 4'b0010;
            if (k == 3) req = 4'b0000;
        end
        wait_idle(400, 8'hB2, cyc, ntx, stable);
        check("L_idle", 32'(busy), 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
